count_sequencer: RTL and testbench
==================================

COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 The block SHALL have parameter WRAP_EN, default 1, meaning 1 = count wraps 9999->0000 and 0 = count saturates at 9999.
REQ-002 The block SHALL have parameter LZ_BLANK, default 1, meaning 1 = leading-zero blanking enabled.
REQ-003 The block SHALL have port clock, input, 1, system clock, all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port inc_level, input, 1, debounced increment button level, synchronous to clock.
REQ-006 The block SHALL have port mode_select, input, 1, raw slide switch (0 = manual, 1 = auto), asynchronous.
REQ-007 The block SHALL have port tick_1hz, input, 1, single-cycle count strobe.
REQ-008 The block SHALL have port tick_1khz, input, 1, single-cycle scan strobe.
REQ-009 The block SHALL have port bcd_count, output, 16, four BCD digits, [3:0] = units.
REQ-010 The block SHALL have port digit_select, output, 4, active-low one-hot anode enable.
REQ-011 The block SHALL have port digit_value, output, 4, BCD value of the currently selected digit.
REQ-012 The block SHALL have port blank, output, 1, high = the segment decoder drives all segments off.
REQ-013 The block SHALL have port state_out, output, 2, current FSM state encoding.

Function
REQ-014 mode_select SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized value mode_s.
REQ-015 inc_edge SHALL be inc_level AND NOT inc_prev, where inc_prev is inc_level registered one cycle.
REQ-016 The FSM SHALL have states MANUAL=2'b00, AUTO_RUN=2'b01 and AUTO_PAUSE=2'b10; 2'b11 SHALL recover to MANUAL on the next edge.
REQ-017 In MANUAL, mode_s=1 SHALL go to AUTO_RUN; in AUTO_RUN or AUTO_PAUSE, mode_s=0 SHALL go to MANUAL; the mode change SHALL take priority over inc_edge.
REQ-018 In AUTO_RUN, inc_edge SHALL go to AUTO_PAUSE; in AUTO_PAUSE, inc_edge SHALL go to AUTO_RUN.
REQ-019 Count step: in MANUAL on inc_edge, SHALL increment; tick_1hz ignored.
REQ-020 Count step: in AUTO_RUN on tick_1hz, SHALL increment; inc_edge only toggles pause, no increment.
REQ-021 Count step: in AUTO_PAUSE, SHALL hold.
REQ-022 In AUTO_RUN, tick_1hz and inc_edge in the same cycle SHALL increment the count and enter AUTO_PAUSE.
REQ-023 On the cycle mode_s changes, SHALL increment only if the step rule of the pre-transition state applies.
REQ-024 bcd_count SHALL update on the edge where the step condition is true, visible the next cycle (1-cycle latency).
REQ-025 Increment SHALL be decimal per digit: 9->0 with carry; every digit SHALL stay in range 0..9.
REQ-026 At 9999, a step SHALL give 0000 if WRAP_EN=1, else hold 9999.
REQ-027 The count SHALL be retained across all mode transitions.
REQ-028 The scan index (2 bits) SHALL advance 0->1->2->3->0 on each tick_1khz.
REQ-029 digit_select SHALL be registered, with index i clearing bit i and the others high.
REQ-030 digit_value SHALL be registered and aligned with digit_select.
REQ-031 blank SHALL be registered; with LZ_BLANK=1 it SHALL be high when the index is >0 and the selected digit and all more-significant digits are 0; digit 0 SHALL never blank; with LZ_BLANK=0, blank SHALL be 0.

Reset
REQ-032 With reset high at a rising edge: bcd_count=16'h0000, state=MANUAL, sync flops=0, inc_prev=0, scan index=0, digit_select=4'b1110, digit_value=0, blank=0.
REQ-033 Reset SHALL override all inputs, including mid-operation and simultaneous ticks.
REQ-034 After reset release with mode_select held 1, the FSM SHALL reach AUTO_RUN on the 3rd rising edge.

Structure
REQ-035 A shared package SHALL hold the FSM state encodings, BCD_MAX=4'd9 and the digit count 4.
REQ-036 One sub-module, bcd_digit (4-bit BCD cell: inputs en and carry_in, outputs value and carry_out), SHALL be instantiated 4 times in a chain.
REQ-037 All outputs SHALL be registered.

Verification
REQ-038 Reset, then 3 inc pulses in MANUAL -> bcd_count=16'h0003; digit_select cycles 1110,1101,1011,0111; blank=1 for digits 1-3.
REQ-039 MANUAL at 16'h0009, one inc pulse -> 16'h0010; at 16'h9999: WRAP_EN=1 -> 16'h0000, WRAP_EN=0 -> 16'h9999.
REQ-040 mode_select=1, 5 tick_1hz strobes from 16'h0003 -> 16'h0008; inc_level held high 10 cycles counts as one edge.
REQ-041 AUTO_RUN with tick_1hz and inc_edge in the same cycle -> count +1, state=AUTO_PAUSE; 3 further ticks -> no change; inc pulse -> AUTO_RUN.
REQ-042 Reset asserted at count 16'h0042 in AUTO_RUN -> next cycle count=0000, state=MANUAL, digit_select=1110.
REQ-043 mode_select toggled 1->0 in AUTO_PAUSE -> MANUAL within 3 edges, count unchanged.

Source files
------------

// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the count sequencer: FSM encodings and BCD geometry.
package count_sequencer_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned COUNT_W    = NUM_DIGITS * DIGIT_W;
   localparam int unsigned SCAN_W     = 2;

   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_MANUAL     = 2'b00,
      ST_AUTO_RUN   = 2'b01,
      ST_AUTO_PAUSE = 2'b10,
      ST_ILLEGAL    = 2'b11
   } state_t;

endpackage : count_sequencer_pkg

// File: rtl/count_sequencer_bcd_digit.sv
// One decimal digit of the counter: advances when enabled and all lower digits roll over.
module bcd_digit
   import count_sequencer_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               en,
   input  logic               carry_in,
   output logic [DIGIT_W-1:0] value,
   output logic               carry_out
);

   logic [DIGIT_W-1:0] r_value;

   assign value     = r_value;
   assign carry_out = carry_in && (r_value == BCD_MAX);

   // Digit register; any out-of-range code is folded back to zero on the next step.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_value <= '0;
      end else if (en && carry_in) begin
         r_value <= (r_value >= BCD_MAX) ? '0 : r_value + DIGIT_W'(1);
      end
   end

endmodule : bcd_digit

// File: rtl/count_sequencer.sv
// Four-digit BCD counter with manual/auto modes and a multiplexed display scanner.
module count_sequencer
   import count_sequencer_pkg::*;
#(
   parameter bit WRAP_EN  = 1'b1,
   parameter bit LZ_BLANK = 1'b1
)
(
   input  logic                clock,
   input  logic                reset,
   input  logic                inc_level,
   input  logic                mode_select,
   input  logic                tick_1hz,
   input  logic                tick_1khz,
   output logic [COUNT_W-1:0]  bcd_count,
   output logic [3:0]          digit_select,
   output logic [DIGIT_W-1:0]  digit_value,
   output logic                blank,
   output logic [1:0]          state_out
);

   logic                                r_mode_meta;
   logic                                r_mode_s;
   logic                                r_inc_prev;
   state_t                              r_state;
   logic [SCAN_W-1:0]                   r_scan_idx;
   logic [3:0]                          r_digit_select;
   logic [DIGIT_W-1:0]                  r_digit_value;
   logic                                r_blank;

   logic                                w_inc_edge;
   logic                                w_step;
   logic                                w_count_en;
   logic [NUM_DIGITS:0]                 w_carry;
   logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  w_digits;
   logic [NUM_DIGITS-1:0]               w_zero;
   logic [SCAN_W-1:0]                   w_scan_next;
   logic                                w_lead_zero;

   // Mode switch synchronizer and increment-button edge history.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_mode_meta <= 1'b0;
         r_mode_s    <= 1'b0;
         r_inc_prev  <= 1'b0;
      end else begin
         r_mode_meta <= mode_select;
         r_mode_s    <= r_mode_meta;
         r_inc_prev  <= inc_level;
      end
   end

   assign w_inc_edge = inc_level && !r_inc_prev;

   // Mode FSM; a mode change wins over a pause toggle in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_MANUAL;
      end else begin
         case (r_state)
            ST_MANUAL: begin
               if (r_mode_s) r_state <= ST_AUTO_RUN;
            end
            ST_AUTO_RUN: begin
               if (!r_mode_s)       r_state <= ST_MANUAL;
               else if (w_inc_edge) r_state <= ST_AUTO_PAUSE;
            end
            ST_AUTO_PAUSE: begin
               if (!r_mode_s)       r_state <= ST_MANUAL;
               else if (w_inc_edge) r_state <= ST_AUTO_RUN;
            end
            default: r_state <= ST_MANUAL;
         endcase
      end
   end

   // Step rule is evaluated on the current (pre-transition) state.
   assign w_step     = ((r_state == ST_MANUAL)   && w_inc_edge) ||
                       ((r_state == ST_AUTO_RUN) && tick_1hz);
   assign w_count_en = w_step && (WRAP_EN || !w_carry[NUM_DIGITS]);
   assign w_carry[0] = 1'b1;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .clock     (clock),
         .reset     (reset),
         .en        (w_count_en),
         .carry_in  (w_carry[g]),
         .value     (w_digits[g]),
         .carry_out (w_carry[g+1])
      );
      assign w_zero[g] = (w_digits[g] == '0);
   end

   assign bcd_count   = w_digits;
   assign w_scan_next = tick_1khz ? r_scan_idx + SCAN_W'(1) : r_scan_idx;

   // Selected digit and everything above it are zero (units never qualifies).
   always_comb begin
      w_lead_zero = 1'b0;
      case (w_scan_next)
         2'd1:    w_lead_zero = &w_zero[3:1];
         2'd2:    w_lead_zero = &w_zero[3:2];
         2'd3:    w_lead_zero = w_zero[3];
         default: w_lead_zero = 1'b0;
      endcase
   end

   // Display scan registers, all driven from the same upcoming index.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_scan_idx     <= '0;
         r_digit_select <= 4'b1110;
         r_digit_value  <= '0;
         r_blank        <= 1'b0;
      end else begin
         r_scan_idx     <= w_scan_next;
         r_digit_select <= ~(4'b0001 << w_scan_next);
         r_digit_value  <= w_digits[w_scan_next];
         r_blank        <= LZ_BLANK && w_lead_zero;
      end
   end

   assign digit_select = r_digit_select;
   assign digit_value  = r_digit_value;
   assign blank        = r_blank;
   assign state_out    = r_state;

endmodule : count_sequencer

// File: tb/tb_count_sequencer.sv
// Directed scoreboard bench for count_sequencer (wrapping and saturating instances).
module tb_count_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        inc_level;
   logic        mode_select;
   logic        tick_1hz;
   logic        tick_1khz;

   logic [15:0] bcd_count,    s_bcd_count;
   logic [3:0]  digit_select, s_digit_select;
   logic [3:0]  digit_value,  s_digit_value;
   logic        blank,        s_blank;
   logic [1:0]  state_out,    s_state_out;

   typedef struct {
      logic [15:0] main;
      logic [15:0] sat;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] m_main;
   logic [15:0] m_sat;
   int          scan_idx;
   int          n_pass;
   int          n_total;
   logic [3:0]  sel_tbl [4];

   count_sequencer #(.WRAP_EN(1'b1), .LZ_BLANK(1'b1)) dut (
      .clock(clock), .reset(reset), .inc_level(inc_level), .mode_select(mode_select),
      .tick_1hz(tick_1hz), .tick_1khz(tick_1khz), .bcd_count(bcd_count),
      .digit_select(digit_select), .digit_value(digit_value), .blank(blank),
      .state_out(state_out)
   );

   count_sequencer #(.WRAP_EN(1'b0), .LZ_BLANK(1'b0)) dut_sat (
      .clock(clock), .reset(reset), .inc_level(inc_level), .mode_select(mode_select),
      .tick_1hz(tick_1hz), .tick_1khz(tick_1khz), .bcd_count(s_bcd_count),
      .digit_select(s_digit_select), .digit_value(s_digit_value), .blank(s_blank),
      .state_out(s_state_out)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      int n;
      n = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
      n = (n + 1) % 10000;
      return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   function automatic logic exp_blank(input logic [15:0] v, input int idx);
      logic [15:0] t;
      t = v;
      if (idx == 0) return 1'b0;
      for (int d = idx; d < 4; d++) begin
         if (t[d*4 +: 4] != 4'd0) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_step();
      m_main = bcd_inc(m_main);
      m_sat  = (m_sat == 16'h9999) ? m_sat : bcd_inc(m_sat);
      sb_q.push_back('{main: m_main, sat: m_sat});
   endtask

   task automatic push_hold();
      sb_q.push_back('{main: m_main, sat: m_sat});
   endtask

   task automatic check_count(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_total++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_wrap"}, bcd_count, e.main);
         check({tag, "_sat"}, s_bcd_count, e.sat);
      end
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         push_hold();
         step();
         check_count(tag);
      end
   endtask

   task automatic inc_pulse(input bit counts, input string tag);
      inc_level = 1'b1;
      if (counts) push_step(); else push_hold();
      step();
      check_count(tag);
      inc_level = 1'b0;
      push_hold();
      step();
      check_count({tag, "_rel"});
   endtask

   task automatic tick_pulse(input bit counts, input string tag);
      tick_1hz = 1'b1;
      if (counts) push_step(); else push_hold();
      step();
      check_count(tag);
      tick_1hz = 1'b0;
   endtask

   task automatic check_scan(input string tag);
      logic [15:0] t;
      t = m_main;
      check({tag, "_sel"},      16'(digit_select), 16'(sel_tbl[scan_idx]));
      check({tag, "_val"},      16'(digit_value),  16'(t[scan_idx*4 +: 4]));
      check({tag, "_blank"},    16'(blank),        16'(exp_blank(t, scan_idx)));
      check({tag, "_nolz"},     16'(s_blank),      16'h0);
   endtask

   task automatic scan_tick(input string tag);
      tick_1khz = 1'b1;
      push_hold();
      step();
      check_count(tag);
      tick_1khz = 1'b0;
      scan_idx = (scan_idx + 1) % 4;
      check_scan(tag);
   endtask

   initial begin
      sel_tbl[0] = 4'b1110;
      sel_tbl[1] = 4'b1101;
      sel_tbl[2] = 4'b1011;
      sel_tbl[3] = 4'b0111;
      n_pass = 0; n_total = 0; scan_idx = 0;
      m_main = 16'h0000; m_sat = 16'h0000;
      reset = 1'b1; inc_level = 1'b0; mode_select = 1'b0; tick_1hz = 1'b0; tick_1khz = 1'b0;
      step(); step();

      // Reset state
      check("rst_count", bcd_count, 16'h0000);
      check("rst_state", 16'(state_out), 16'h0000);
      check("rst_sel",   16'(digit_select), 16'h000E);
      check("rst_val",   16'(digit_value), 16'h0000);
      check("rst_blank", 16'(blank), 16'h0000);
      reset = 1'b0;

      // Manual counting: three pulses, then display scan with blanking
      for (int i = 0; i < 3; i++) inc_pulse(1'b1, "man_inc");
      check("man_003", bcd_count, 16'h0003);
      check_scan("scan3_d0");
      for (int i = 0; i < 4; i++) scan_tick("scan3");

      // Decimal carry 0009 -> 0010
      for (int i = 0; i < 7; i++) inc_pulse(1'b1, "man_carry");
      check("man_010", bcd_count, 16'h0010);
      check_scan("scan10_d0");
      for (int i = 0; i < 4; i++) scan_tick("scan10");

      // tick_1hz ignored in manual
      tick_pulse(1'b0, "man_tick_ign");
      idle(1, "man_idle");

      // Enter auto: state changes on the 3rd edge
      mode_select = 1'b1;
      idle(2, "sync");
      check("sync_still_man", 16'(state_out), 16'h0000);
      idle(1, "sync");
      check("auto_run", 16'(state_out), 16'h0001);

      for (int i = 0; i < 5; i++) begin
         tick_pulse(1'b1, "auto_tick");
         idle(1, "auto_gap");
      end
      check("auto_015", bcd_count, 16'h0015);

      // Held inc_level counts as one edge: pause without increment
      inc_level = 1'b1;
      idle(10, "inc_held");
      check("held_pause", 16'(state_out), 16'h0002);
      inc_level = 1'b0;
      idle(1, "inc_rel");
      inc_pulse(1'b0, "resume");
      check("resumed", 16'(state_out), 16'h0001);

      // Same-cycle tick and inc edge: count and pause
      tick_1hz = 1'b1; inc_level = 1'b1;
      push_step();
      step();
      check_count("tick_and_inc");
      check("tick_inc_pause", 16'(state_out), 16'h0002);
      tick_1hz = 1'b0; inc_level = 1'b0;
      idle(1, "tick_inc_rel");
      for (int i = 0; i < 3; i++) tick_pulse(1'b0, "paused_tick");
      idle(1, "paused_idle");
      check("paused_016", bcd_count, 16'h0016);
      inc_pulse(1'b0, "unpause");
      check("unpaused", 16'(state_out), 16'h0001);

      // Mode off while paused: back to manual within 3 edges, count kept
      inc_pulse(1'b0, "pause2");
      check("pause2_state", 16'(state_out), 16'h0002);
      mode_select = 1'b0;
      idle(3, "to_manual");
      check("pause_to_man", 16'(state_out), 16'h0000);
      check("pause_to_man_cnt", bcd_count, 16'h0016);

      // Run up to 0042 in auto, then reset with every input active
      mode_select = 1'b1;
      idle(3, "re_auto");
      check("re_auto_state", 16'(state_out), 16'h0001);
      tick_1hz = 1'b1;
      while (m_main != 16'h0042) begin
         push_step();
         step();
         check_count("run42");
      end
      reset = 1'b1; tick_1khz = 1'b1; inc_level = 1'b1;
      step();
      sb_q.delete();
      m_main = 16'h0000; m_sat = 16'h0000; scan_idx = 0;
      check("mid_rst_count", bcd_count, 16'h0000);
      check("mid_rst_sat",   s_bcd_count, 16'h0000);
      check("mid_rst_state", 16'(state_out), 16'h0000);
      check("mid_rst_sel",   16'(digit_select), 16'h000E);
      reset = 1'b0; tick_1hz = 1'b0; tick_1khz = 1'b0; inc_level = 1'b0;

      // Mode held high across release: AUTO_RUN on the 3rd edge
      idle(1, "rel1");
      check("rel_edge1", 16'(state_out), 16'h0000);
      idle(1, "rel2");
      check("rel_edge2", 16'(state_out), 16'h0000);
      idle(1, "rel3");
      check("rel_edge3", 16'(state_out), 16'h0001);

      // Count to 9999, then wrap versus saturate
      tick_1hz = 1'b1;
      for (int i = 0; i < 9999; i++) begin
         push_step();
         step();
         check_count("to9999");
      end
      check("at9999_wrap", bcd_count, 16'h9999);
      check("at9999_sat",  s_bcd_count, 16'h9999);
      for (int i = 0; i < 2; i++) begin
         push_step();
         step();
         check_count("past9999");
      end
      tick_1hz = 1'b0;
      check("wrapped", bcd_count, 16'h0001);
      check("saturated", s_bcd_count, 16'h9999);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_count_sequencer
